down_count_60: RTL and testbench
================================

// Module: down_count_60
// PURPOSE
//  Loadable modulo-60 BCD down counter with borrow out (seconds/minutes countdown stage).
//  Counterpart of the mod-60 up counter: decrements one step per enabled clock.
//  On 00 it wraps to 59 and raises a borrow, so stages cascade into an MM:SS countdown timer.
//  Built as a ones digit (0-9) feeding a tens digit (0-5), like the up-count chain.
// PARAMETERS
//  RESET_VAL  7'd0  value loaded on reset; 0..59, values above 59 are illegal
// PORTS
//  clk        in   1  system clock; all state updates on rising edge
//  rst        in   1  synchronous, active-high reset
//  en         in   1  decrement request; one step per cycle while high
//  load       in   1  parallel load strobe
//  load_tens  in   3  tens digit to load (0-5)
//  load_ones  in   4  ones digit to load (0-9)
//  tens       out  3  current tens digit
//  ones       out  4  current ones digit
//  count      out  7  binary value, tens*10 + ones (0..59)
//  zero       out  1  high while count == 0
//  bo         out  1  borrow out = en & zero & ~load & ~rst (combinational)
// BEHAVIOUR
//  - Priority per cycle: rst > load > en > hold.
//  - rst: tens/ones <= RESET_VAL split into BCD next cycle; count=RESET_VAL; bo=0.
//  - load: digits captured next edge. Out-of-range digits saturate: ones>9 -> 9, tens>5 -> 5.
//    load with en in the same cycle: load wins and no decrement happens.
//  - en (no load): ones>0 -> ones-1. ones==0 -> ones=9 and the tens digit decrements.
//    tens==0 with ones==0 -> wrap to 59 (tens=5, ones=9).
//  - The tens digit decrements only when en is high and ones==0.
//  - The ones-digit borrow is combinational: en & (ones==0).
//  - Latency: the new value is visible on count the cycle after the en/load edge.
//    count, zero and bo are combinational from registered digits and inputs.
//  - bo is high in the same cycle as the 00->59 wrap decision.
//    Connect it to the next stage's en for cascading.
//  - en held high continuously: full period of 60 cycles; bo high exactly 1 cycle in 60.
//  - rst while en is high: reset wins, no borrow is emitted, and counting resumes from
//    RESET_VAL the next cycle.
//  - Digits never leave their legal range in any state.
// CONFIGURATION
//  DOWN_COUNT_60_STOP_EN defined: terminal-count mode. At 00 with en, the counter holds 00
//    and does not wrap. bo still asserts for every en cycle at 00, so the downstream stage
//    sees "expired". Only load or rst leaves 00.
//  DOWN_COUNT_60_STOP_EN undefined: free-running wrap 00->59 as described above.
// STRUCTURE
//  - Shared package/header count60_pkg: DIGIT_ONES_MAX=4'd9, DIGIT_TENS_MAX=3'd5, MOD60=60,
//    plus a BCD-to-binary helper function (tens*10+ones).
//  - One sub-module: down_count_10.
//    Ports: clk, rst, en, load, load_val[3:0], count[3:0], bo.
//    Behaviour: mod-10 down digit whose borrow is en & (count==0).
//  - The tens digit is a 3-bit mod-6 down counter inline in the top.
//    Its en is the ones-digit borrow.
// TESTING
//  1. rst=1 for one cycle, RESET_VAL=0 -> count=0, zero=1, bo=0. Then en=1 for one cycle
//     -> bo=1 that cycle, next count=59 (tens=5, ones=9).
//  2. load tens=3, ones=0, then en=1 for one cycle -> count=29, tens=2, ones=9, bo=0.
//  3. load tens=7, ones=12 (illegal) -> count=59. Then load and en both high with 2/5
//     -> count=25, no decrement.
//  4. en high for 120 cycles from 59 -> count sequence 59..0 twice; bo high exactly
//     2 cycles, each when count==0.
//  5. count=10 with en=1, and rst asserted in the next cycle -> count=RESET_VAL, bo=0
//     during the reset cycle.
//  6. Build with DOWN_COUNT_60_STOP_EN: load 0/1, en high for 5 cycles -> count 1,0,0,0,0;
//     bo=1 on the last 4 cycles; then load 4/0 -> count=40.

Source files
------------

// File: rtl/count60_pkg.sv
// -----------------------------------------------------------------------------
// count60_pkg
// Shared constants and helpers for the modulo-60 BCD counter stages.
//   DIGIT_ONES_MAX : largest legal ones digit (9)
//   DIGIT_TENS_MAX : largest legal tens digit (5)
//   MOD60          : counter modulus
//   bcd_to_bin()   : tens*10 + ones as a 7-bit binary value
// -----------------------------------------------------------------------------
package count60_pkg;

    localparam logic [3:0] DIGIT_ONES_MAX = 4'd9;
    localparam logic [2:0] DIGIT_TENS_MAX = 3'd5;
    localparam int         MOD60          = 60;

    function automatic logic [6:0] bcd_to_bin(input logic [2:0] tens, input logic [3:0] ones);
        return ({4'd0, tens} * 7'd10) + {3'd0, ones};
    endfunction

endpackage

// File: rtl/down_count_10.sv
// -----------------------------------------------------------------------------
// down_count_10
// Modulo-10 BCD down-counting digit with parallel load and borrow out.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset (loads RESET_VAL)
//   en        in   decrement request
//   load      in   parallel load strobe (wins over en)
//   load_val  in   [3:0] digit to load; values above 9 saturate to 9
//   count     out  [3:0] current digit
//   bo        out  borrow = en & (count == 0)
// -----------------------------------------------------------------------------
module down_count_10
    import count60_pkg::*;
#(
    parameter logic [3:0] RESET_VAL = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] count,
    output logic       bo
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = (load_val > DIGIT_ONES_MAX) ? DIGIT_ONES_MAX : load_val;
        end else if (en) begin
            count_d = (count_q == 4'd0) ? DIGIT_ONES_MAX : count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign bo    = en & (count_q == 4'd0);

endmodule

// File: rtl/down_count_60.sv
// -----------------------------------------------------------------------------
// down_count_60
// Loadable modulo-60 BCD down counter with borrow out, one cascadable stage of
// an MM:SS countdown timer. A ones digit (down_count_10) borrows into an inline
// mod-6 tens digit.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset (loads RESET_VAL)
//   en         in   decrement request, one step per cycle
//   load       in   parallel load strobe (wins over en)
//   load_tens  in   [2:0] tens digit to load, saturates at 5
//   load_ones  in   [3:0] ones digit to load, saturates at 9
//   tens       out  [2:0] current tens digit
//   ones       out  [3:0] current ones digit
//   count      out  [6:0] tens*10 + ones
//   zero       out  high while count == 0
//   bo         out  borrow out = en & zero & ~load & ~rst
// Configuration macro DOWN_COUNT_60_STOP_EN: when defined the counter holds at
// 00 instead of wrapping to 59 (bo still asserts on every enabled cycle at 00).
// -----------------------------------------------------------------------------
module down_count_60
    import count60_pkg::*;
#(
    parameter logic [6:0] RESET_VAL = 7'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [2:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [2:0] tens,
    output logic [3:0] ones,
    output logic [6:0] count,
    output logic       zero,
    output logic       bo
);

    localparam logic [2:0] RST_TENS = 3'(RESET_VAL / 7'd10);
    localparam logic [3:0] RST_ONES = 4'(RESET_VAL % 7'd10);

    logic [2:0] tens_q;
    logic [2:0] tens_d;
    logic [3:0] ones_w;
    logic       ones_en;
    logic       ones_bo;
    logic       zero_w;

    assign zero_w = (tens_q == 3'd0) && (ones_w == 4'd0);

`ifdef DOWN_COUNT_60_STOP_EN
    // Terminal-count mode: suppress the decrement at 00 so neither digit wraps.
    assign ones_en = en & ~zero_w;
`else
    assign ones_en = en;
`endif

    down_count_10 #(
        .RESET_VAL (RST_ONES)
    ) u_ones (
        .clk      (clk),
        .rst      (rst),
        .en       (ones_en),
        .load     (load),
        .load_val (load_ones),
        .count    (ones_w),
        .bo       (ones_bo)
    );

    // Tens digit: mod-6 down counter stepped by the ones-digit borrow.
    always_comb begin
        tens_d = tens_q;
        if (load) begin
            tens_d = (load_tens > DIGIT_TENS_MAX) ? DIGIT_TENS_MAX : load_tens;
        end else if (ones_bo) begin
            tens_d = (tens_q == 3'd0) ? DIGIT_TENS_MAX : tens_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q <= RST_TENS;
        end else begin
            tens_q <= tens_d;
        end
    end

    assign tens  = tens_q;
    assign ones  = ones_w;
    assign count = bcd_to_bin(tens_q, ones_w);
    assign zero  = zero_w;
    // Reset and load both pre-empt the decrement, so neither may emit a borrow.
    assign bo    = en & zero_w & ~load & ~rst;

endmodule

// File: tb/tb_down_count_60.sv
// -----------------------------------------------------------------------------
// tb_down_count_60
// Directed self-checking bench for down_count_60 (RESET_VAL = 0).
// -----------------------------------------------------------------------------
module tb_down_count_60;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [2:0] load_tens;
    logic [3:0] load_ones;
    logic [2:0] tens;
    logic [3:0] ones;
    logic [6:0] count;
    logic       zero;
    logic       bo;

    int n_checks = 0;
    int n_pass   = 0;

    down_count_60 #(
        .RESET_VAL (7'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .load_tens (load_tens),
        .load_ones (load_ones),
        .tens      (tens),
        .ones      (ones),
        .count     (count),
        .zero      (zero),
        .bo        (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
            $display("check %-14s got=%0d exp=%0d ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge; inputs may be changed right after return.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int t, input int o);
        load      = 1'b1;
        en        = 1'b0;
        load_tens = 3'(t);
        load_ones = 4'(o);
        step();
        load = 1'b0;
    endtask

    int bo_cnt;
    int exp_v;

    initial begin
        rst = 1'b0; en = 1'b0; load = 1'b0; load_tens = '0; load_ones = '0;
        #2;

        // 1. reset, then one enabled cycle at 00 wraps to 59
        rst = 1'b1;
        #1 check("rst_bo", bo, 0);
        step();
        rst = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_zero", zero, 1);
        check("rst_bo_after", bo, 0);
        en = 1'b1;
        #1 check("wrap_bo", bo, 1);
        step();
        en = 1'b0;
        #1;
        check("wrap_count", count, 59);
        check("wrap_tens", tens, 5);
        check("wrap_ones", ones, 9);
        check("wrap_zero", zero, 0);

        // 2. load 30, one decrement -> 29
        do_load(3, 0);
        check("load30", count, 30);
        en = 1'b1;
        #1 check("dec30_bo", bo, 0);
        step();
        en = 1'b0;
        #1;
        check("dec_count", count, 29);
        check("dec_tens", tens, 2);
        check("dec_ones", ones, 9);

        // 3. illegal digits saturate; load wins over en
        do_load(7, 12);
        check("sat_count", count, 59);
        load = 1'b1; en = 1'b1; load_tens = 3'd2; load_ones = 4'd5;
        step();
        load = 1'b0; en = 1'b0;
        #1 check("ld_en_count", count, 25);

        // load + en at 00: no borrow and no wrap
        do_load(0, 0);
        check("ld00", count, 0);
        load = 1'b1; en = 1'b1; load_tens = 3'd0; load_ones = 4'd0;
        #1 check("ld_en_bo", bo, 0);
        step();
        load = 1'b0; en = 1'b0;
        #1 check("ld_en_00", count, 0);

`ifndef DOWN_COUNT_60_STOP_EN
        // 4. 120 enabled cycles from 59: two full periods, bo exactly twice
        do_load(5, 9);
        en = 1'b1;
        bo_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            #1;
            exp_v = 59 - (i % 60);
            check("run_count", count, exp_v);
            check("run_bo", bo, (exp_v == 0) ? 1 : 0);
            if (bo) bo_cnt++;
            step();
        end
        en = 1'b0;
        #1;
        check("run_bo_total", bo_cnt, 2);
        check("run_end", count, 59);
`endif

        // 5. count 10 with en, then rst while en high
        do_load(1, 0);
        en = 1'b1;
        step();
        #1 check("pre_rst", count, 9);
        rst = 1'b1;
        #1 check("rst_en_bo", bo, 0);
        step();
        rst = 1'b0;
        #1;
        check("rst_en_cnt", count, 0);
        check("resume_bo", bo, 1);
        step();
        en = 1'b0;
`ifdef DOWN_COUNT_60_STOP_EN
        #1 check("resume_cnt", count, 0);
`else
        #1 check("resume_cnt", count, 59);
`endif

`ifdef DOWN_COUNT_60_STOP_EN
        // 6. terminal-count mode: hold at 00, bo on each enabled cycle there
        do_load(0, 1);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stop_count", count, (i == 0) ? 1 : 0);
            check("stop_bo", bo, (i == 0) ? 0 : 1);
            step();
        end
        en = 1'b0;
        do_load(4, 0);
        check("stop_reload", count, 40);
`else
        // free-running: 01 -> 00 -> 59
        do_load(0, 1);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("free_count", count, (i == 0) ? 1 : (i == 1) ? 0 : 59);
            step();
        end
        en = 1'b0;
        do_load(4, 0);
        check("reload40", count, 40);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
